// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush, external hold and a saturating stall-cycle counter.
`timescale 1ns/1ps

module pipe_stage_reg #(
    parameter int                CNT_W       = 32,
    parameter int                DATA_W      = 96,
    parameter bit                SKID_EN     = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_fire;
    logic              out_fire;
    logic              stall;

    // With the skid buffer, in_ready never looks at out_ready, which breaks the
    // combinational ready path back to the upstream stage.
    generate
        if (SKID_EN) begin : g_skid
            assign in_ready = (state_q != FULL2) & ~hold_i;
        end else begin : g_noskid
            assign in_ready = ((state_q == EMPTY) | out_ready) & ~hold_i;
        end
    endgenerate

    assign out_valid = (state_q != EMPTY) & ~hold_i;
    assign out_data  = (state_q != EMPTY) ? main_q : BUBBLE_DATA;
    assign occupancy = state_q;
    assign stall_cnt = cnt_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign stall    = (out_valid & ~out_ready) | hold_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = BUBBLE_DATA;
            skid_d  = BUBBLE_DATA;
        end else if (!hold_i) begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = FULL1;
                        main_d  = in_data;
                    end
                end
                FULL1: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE_DATA;
                    end else if (in_fire && SKID_EN) begin
                        state_d = FULL2;
                        skid_d  = in_data;
                    end
                end
                FULL2: begin
                    if (out_fire) begin
                        state_d = FULL1;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_DATA;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_DATA;
                    skid_d  = BUBBLE_DATA;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE_DATA;
            skid_q  <= BUBBLE_DATA;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
